rename_regfile: RTL and testbench
=================================

RENAME_REGFILE -- requirements
Module: rename_regfile

Interface
REQ-001 SHALL have parameter XLEN, default 32, register data width.
REQ-002 SHALL have parameter ROB_WIDTH, default 4, ROB tag width.
REQ-003 SHALL have parameter CKPT_DEPTH, default 4, power of two, number of rename-map checkpoints.
REQ-004 SHALL have ports: clk_in  in  1  system clock; rst_in  in  1  reset, asynchronous, active-high; rdy_in  in  1  pause when low.
REQ-005 SHALL have issue ports: issue_valid in 1; rs1_id, rs2_id, rd_id in 5 each; rd_tag in ROB_WIDTH; ckpt_req in 1, snapshot the map after this issue.
REQ-006 SHALL have issue outputs: rs1_value, rs2_value out XLEN; rs1_tag, rs2_tag out ROB_WIDTH; rs1_ready, rs2_ready out 1; value_x1 out XLEN.
REQ-007 SHALL have commit ports: commit_valid in 1; commit_rd_id in 5; commit_tag in ROB_WIDTH; commit_value in XLEN.
REQ-008 SHALL have recovery ports: resolve_valid in 1, oldest checkpointed branch resolved; resolve_mispredict in 1; flush_all in 1, exception-style full clear.
REQ-009 SHALL have status outputs: ckpt_full out 1; ckpt_empty out 1; ckpt_count out log2(CKPT_DEPTH)+1.

Function
REQ-010 SHALL hold 32 entries each {value, tag, busy}; x0 always reads value 0, ready 1, and is never renamed or written.
REQ-011 Read outputs SHALL be combinational; rsN_ready = ~busy, or 1 with rsN_value = commit_value when commit_valid and busy and tag equals commit_tag (same-cycle bypass).
REQ-012 value_x1 SHALL be the architectural value of x1, no bypass.
REQ-013 No state SHALL change when rdy_in is low.
REQ-014 On issue_valid, rd_id != 0: busy[rd]<=1, tag[rd]<=rd_tag at the clock edge.
REQ-015 On commit_valid, commit_rd_id != 0: value<=commit_value always; busy<=0 only if busy, tag matches commit_tag, and no same-cycle issue renames the same register.
REQ-016 Checkpoints SHALL form a FIFO of {tag[31:1], busy[31:1]} snapshots with wrap-around head/tail pointers.
REQ-017 On issue_valid & ckpt_req & ~ckpt_full: push snapshot equal to the map after this cycle's issue and commit updates; ckpt_count+1.
REQ-018 ckpt_req while ckpt_full SHALL be dropped (no push, count unchanged); the rename itself still applies.
REQ-019 Every cycle, a commit clearing busy per REQ-015 rules SHALL also clear busy of that register in every live snapshot whose stored tag matches commit_tag.
REQ-020 resolve_valid & ~resolve_mispredict: pop oldest snapshot, count-1, map unchanged.
REQ-021 resolve_valid & resolve_mispredict: replace tag/busy map with oldest snapshot (after same-cycle commit clearing per REQ-019), empty the FIFO, count=0; same-cycle issue ignored.
REQ-022 resolve_valid with ckpt_empty SHALL be ignored.
REQ-023 flush_all: all busy<=0, tags<=0, FIFO emptied; values still take same-cycle commit; overrides resolve and issue.
REQ-024 Priority: flush_all > mispredict restore > issue/checkpoint push > commit busy clear; simultaneous push and non-mispredict pop SHALL leave count unchanged.
REQ-025 ckpt_full = (count == CKPT_DEPTH); ckpt_empty = (count == 0).

Reset
REQ-026 rst_in high SHALL asynchronously set all values 0, tags 0, busy 0, FIFO pointers 0, count 0; outputs then: ckpt_empty 1, ckpt_full 0, rsN_ready 1, rsN_value 0, value_x1 0.
REQ-027 Reset mid-operation SHALL discard all live snapshots; no partial state survives.

Verification
REQ-028 Issue rd=5 tag=3, next cycle commit rd=5 tag=3 value 0x1234 while reading rs1=5 -> rs1_ready=1, rs1_value=0x1234; after edge busy[5]=0.
REQ-029 Issue rd=7 tag=2 with ckpt_req, then issue rd=7 tag=4, then mispredict -> tag[7]=2, busy[7]=1, count=0.
REQ-030 Same as REQ-029 but commit tag=2 rd=7 value 9 before mispredict -> after restore busy[7]=0, value[7]=9.
REQ-031 Push 4 checkpoints -> ckpt_full=1; fifth ckpt_req dropped; one correct resolve -> count=3; push and pop same cycle -> count stays 3.
REQ-032 Issue rd=8 and commit rd=8 old tag in same cycle -> busy[8]=1, tag[8]=new tag, value[8]=committed value.
REQ-033 Assert rst_in asynchronously between edges with 2 live checkpoints -> ckpt_count=0 and all rsN_ready=1 immediately.

Source files
------------

// File: rtl/rename_regfile_if.sv
// Bundled issue/commit/recovery/status signals of the rename register file.
// The DUT connects via the slave modport; the driving core uses master.
interface rename_regfile_if #(
  parameter int XLEN       = 32,
  parameter int ROB_WIDTH  = 4,
  parameter int CKPT_DEPTH = 4
);
  localparam int CW = $clog2(CKPT_DEPTH) + 1;

  logic                 issue_valid;
  logic [4:0]           rs1_id;
  logic [4:0]           rs2_id;
  logic [4:0]           rd_id;
  logic [ROB_WIDTH-1:0] rd_tag;
  logic                 ckpt_req;

  logic [XLEN-1:0]      rs1_value;
  logic [XLEN-1:0]      rs2_value;
  logic [ROB_WIDTH-1:0] rs1_tag;
  logic [ROB_WIDTH-1:0] rs2_tag;
  logic                 rs1_ready;
  logic                 rs2_ready;
  logic [XLEN-1:0]      value_x1;

  logic                 commit_valid;
  logic [4:0]           commit_rd_id;
  logic [ROB_WIDTH-1:0] commit_tag;
  logic [XLEN-1:0]      commit_value;

  logic                 resolve_valid;
  logic                 resolve_mispredict;
  logic                 flush_all;

  logic                 ckpt_full;
  logic                 ckpt_empty;
  logic [CW-1:0]        ckpt_count;

  modport master (
    output issue_valid, rs1_id, rs2_id, rd_id, rd_tag, ckpt_req,
    output commit_valid, commit_rd_id, commit_tag, commit_value,
    output resolve_valid, resolve_mispredict, flush_all,
    input  rs1_value, rs2_value, rs1_tag, rs2_tag, rs1_ready, rs2_ready, value_x1,
    input  ckpt_full, ckpt_empty, ckpt_count
  );

  modport slave (
    input  issue_valid, rs1_id, rs2_id, rd_id, rd_tag, ckpt_req,
    input  commit_valid, commit_rd_id, commit_tag, commit_value,
    input  resolve_valid, resolve_mispredict, flush_all,
    output rs1_value, rs2_value, rs1_tag, rs2_tag, rs1_ready, rs2_ready, value_x1,
    output ckpt_full, ckpt_empty, ckpt_count
  );
endinterface

// File: rtl/rename_regfile.sv
// Architectural register file with rename map (tag/busy) and a FIFO of map
// checkpoints for branch recovery; commits scrub matching tags in snapshots.
module rename_regfile #(
  parameter int XLEN       = 32,
  parameter int ROB_WIDTH  = 4,
  parameter int CKPT_DEPTH = 4
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic rdy_in,
  rename_regfile_if.slave bus
);
  localparam int PW = $clog2(CKPT_DEPTH);
  localparam int CW = PW + 1;

  typedef logic [31:0][ROB_WIDTH-1:0] tag_map_t;

  logic [XLEN-1:0] value_q [32];
  logic [XLEN-1:0] value_d [32];
  tag_map_t        tag_q, tag_d;
  logic [31:0]     busy_q, busy_d;
  tag_map_t        ck_tag_q  [CKPT_DEPTH];
  tag_map_t        ck_tag_d  [CKPT_DEPTH];
  logic [31:0]     ck_busy_q [CKPT_DEPTH];
  logic [31:0]     ck_busy_d [CKPT_DEPTH];
  logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;

  logic            full, empty;
  logic            issue_rn, commit_wr, commit_clr;
  logic            push, pop, restore;
  logic            rs1_hit, rs2_hit;
  logic [CKPT_DEPTH-1:0] live;

  assign full       = (count_q == CW'(CKPT_DEPTH));
  assign empty      = (count_q == '0);
  assign issue_rn   = bus.issue_valid && (bus.rd_id != 5'd0);
  assign commit_wr  = bus.commit_valid && (bus.commit_rd_id != 5'd0);
  assign commit_clr = commit_wr && busy_q[bus.commit_rd_id] &&
                      (tag_q[bus.commit_rd_id] == bus.commit_tag) &&
                      !(issue_rn && (bus.rd_id == bus.commit_rd_id));
  assign push       = bus.issue_valid && bus.ckpt_req && !full;
  assign pop        = bus.resolve_valid && !bus.resolve_mispredict && !empty;
  assign restore    = bus.resolve_valid && bus.resolve_mispredict && !empty;

  // Entry 0 is never renamed or written, so it reads as value 0 / ready.
  assign rs1_hit       = bus.commit_valid && busy_q[bus.rs1_id] && (tag_q[bus.rs1_id] == bus.commit_tag);
  assign rs2_hit       = bus.commit_valid && busy_q[bus.rs2_id] && (tag_q[bus.rs2_id] == bus.commit_tag);
  assign bus.rs1_ready = !busy_q[bus.rs1_id] || rs1_hit;
  assign bus.rs2_ready = !busy_q[bus.rs2_id] || rs2_hit;
  assign bus.rs1_value = rs1_hit ? bus.commit_value : value_q[bus.rs1_id];
  assign bus.rs2_value = rs2_hit ? bus.commit_value : value_q[bus.rs2_id];
  assign bus.rs1_tag   = tag_q[bus.rs1_id];
  assign bus.rs2_tag   = tag_q[bus.rs2_id];
  assign bus.value_x1  = value_q[1];
  assign bus.ckpt_full  = full;
  assign bus.ckpt_empty = empty;
  assign bus.ckpt_count = count_q;

  always_comb begin
    live = '0;
    for (int i = 0; i < CKPT_DEPTH; i++)
      live[i] = ({1'b0, PW'(i) - head_q} < count_q);
  end

  always_comb begin
    value_d   = value_q;
    tag_d     = tag_q;
    busy_d    = busy_q;
    ck_tag_d  = ck_tag_q;
    ck_busy_d = ck_busy_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    if (rdy_in) begin
      if (commit_wr) value_d[bus.commit_rd_id] = bus.commit_value;
      if (commit_clr) busy_d[bus.commit_rd_id] = 1'b0;
      // Snapshots are scrubbed on their own stored tag, independent of the live map.
      for (int i = 0; i < CKPT_DEPTH; i++)
        if (commit_wr && live[i] && (ck_tag_q[i][bus.commit_rd_id] == bus.commit_tag))
          ck_busy_d[i][bus.commit_rd_id] = 1'b0;
      if (bus.flush_all) begin
        tag_d   = '0;
        busy_d  = '0;
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
      end else if (restore) begin
        tag_d   = ck_tag_d[head_q];
        busy_d  = ck_busy_d[head_q];
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
      end else begin
        if (issue_rn) begin
          busy_d[bus.rd_id] = 1'b1;
          tag_d[bus.rd_id]  = bus.rd_tag;
        end
        if (push) begin
          ck_tag_d[tail_q]  = tag_d;
          ck_busy_d[tail_q] = busy_d;
          tail_d            = tail_q + PW'(1);
        end
        if (pop) head_d = head_q + PW'(1);
        count_d = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      value_q   <= '{default: '0};
      tag_q     <= '0;
      busy_q    <= '0;
      ck_tag_q  <= '{default: '0};
      ck_busy_q <= '{default: '0};
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
    end else begin
      value_q   <= value_d;
      tag_q     <= tag_d;
      busy_q    <= busy_d;
      ck_tag_q  <= ck_tag_d;
      ck_busy_q <= ck_busy_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
    end
  end
endmodule

// File: tb/tb_rename_regfile.sv
// Directed bench for rename_regfile: stimulus queues expected observations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_rename_regfile;
  localparam int XLEN = 32;
  localparam int RW   = 4;
  localparam int CD   = 4;

  localparam int S_V1 = 0, S_R1 = 1, S_T1 = 2, S_V2 = 3, S_R2 = 4, S_T2 = 5;
  localparam int S_X1 = 6, S_CNT = 7, S_FULL = 8, S_EMPTY = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1;
  always #5 clk = ~clk;

  rename_regfile_if #(.XLEN(XLEN), .ROB_WIDTH(RW), .CKPT_DEPTH(CD)) bus ();

  rename_regfile #(.XLEN(XLEN), .ROB_WIDTH(RW), .CKPT_DEPTH(CD)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .rdy_in (rdy),
    .bus    (bus.slave)
  );

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } chk_t;

  chk_t sb[$];
  chk_t mon_c;
  logic [31:0] mon_act;
  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] obs(input int sel);
    case (sel)
      S_V1:    return bus.rs1_value;
      S_R1:    return {31'b0, bus.rs1_ready};
      S_T1:    return {28'b0, bus.rs1_tag};
      S_V2:    return bus.rs2_value;
      S_R2:    return {31'b0, bus.rs2_ready};
      S_T2:    return {28'b0, bus.rs2_tag};
      S_X1:    return bus.value_x1;
      S_CNT:   return 32'(bus.ckpt_count);
      S_FULL:  return {31'b0, bus.ckpt_full};
      S_EMPTY: return {31'b0, bus.ckpt_empty};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      mon_c   = sb.pop_front();
      mon_act = obs(mon_c.sel);
      checks++;
      if (mon_act !== mon_c.exp) begin
        errors++;
        $display("FAIL %s: actual=%0h expected=%0h", mon_c.name, mon_act, mon_c.exp);
      end
    end
  end

  task automatic expect_v(input string n, input int sel, input logic [31:0] e);
    chk_t c;
    c.name = n;
    c.sel  = sel;
    c.exp  = e;
    sb.push_back(c);
  endtask

  task automatic clr();
    bus.issue_valid        = 1'b0;
    bus.rs1_id             = 5'd0;
    bus.rs2_id             = 5'd0;
    bus.rd_id              = 5'd0;
    bus.rd_tag             = '0;
    bus.ckpt_req           = 1'b0;
    bus.commit_valid       = 1'b0;
    bus.commit_rd_id       = 5'd0;
    bus.commit_tag         = '0;
    bus.commit_value       = '0;
    bus.resolve_valid      = 1'b0;
    bus.resolve_mispredict = 1'b0;
    bus.flush_all          = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic issue(input logic [4:0] rd, input logic [RW-1:0] tag, input logic ck);
    bus.issue_valid = 1'b1;
    bus.rd_id       = rd;
    bus.rd_tag      = tag;
    bus.ckpt_req    = ck;
  endtask

  task automatic commit(input logic [4:0] rd, input logic [RW-1:0] tag, input logic [XLEN-1:0] v);
    bus.commit_valid = 1'b1;
    bus.commit_rd_id = rd;
    bus.commit_tag   = tag;
    bus.commit_value = v;
  endtask

  task automatic resolve(input logic mis);
    bus.resolve_valid      = 1'b1;
    bus.resolve_mispredict = mis;
  endtask

  task automatic rd_ids(input logic [4:0] a, input logic [4:0] b);
    bus.rs1_id = a;
    bus.rs2_id = b;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    clr();
    repeat (2) @(posedge clk);
    #1;
    rd_ids(5, 31);
    expect_v("rst_v1", S_V1, 0);
    expect_v("rst_r1", S_R1, 1);
    expect_v("rst_r2", S_R2, 1);
    expect_v("rst_x1", S_X1, 0);
    expect_v("rst_cnt", S_CNT, 0);
    expect_v("rst_empty", S_EMPTY, 1);
    expect_v("rst_full", S_FULL, 0);
    tick(); rst = 1'b0;

    // value_x1 has no bypass; an idle register does not bypass either
    tick(); commit(1, 0, 32'hABCD); rd_ids(1, 0);
    expect_v("x1_nobyp", S_X1, 0);
    expect_v("x1_rd_nobyp", S_V1, 0);
    tick(); rd_ids(1, 0);
    expect_v("x1_after", S_X1, 32'hABCD);
    expect_v("x1_rd_after", S_V1, 32'hABCD);

    // issue then commit with same-cycle bypass
    tick(); issue(5, 3, 0); rd_ids(5, 0);
    expect_v("r5_pre_issue", S_R1, 1);
    tick(); rd_ids(5, 0);
    expect_v("r5_busy", S_R1, 0);
    expect_v("r5_tag", S_T1, 3);
    tick(); commit(5, 3, 32'h1234); rd_ids(5, 5);
    expect_v("r5_byp_rdy", S_R1, 1);
    expect_v("r5_byp_val", S_V1, 32'h1234);
    expect_v("r5_byp_val2", S_V2, 32'h1234);
    tick(); rd_ids(5, 0);
    expect_v("r5_clear", S_R1, 1);
    expect_v("r5_val", S_V1, 32'h1234);

    // paused: nothing changes
    tick(); rdy = 1'b0; issue(9, 5, 1); commit(9, 5, 77);
    tick(); rdy = 1'b1; rd_ids(9, 0);
    expect_v("pause_rdy", S_R1, 1);
    expect_v("pause_val", S_V1, 0);
    expect_v("pause_cnt", S_CNT, 0);

    // checkpoint then mispredict restores older rename
    tick(); issue(7, 2, 1);
    tick(); issue(7, 4, 0); rd_ids(7, 0);
    expect_v("m1_tag_pre", S_T1, 2);
    expect_v("m1_cnt", S_CNT, 1);
    expect_v("m1_empty", S_EMPTY, 0);
    tick(); resolve(1); issue(9, 6, 0); rd_ids(7, 9);
    expect_v("m1_tag_new", S_T1, 4);
    tick(); rd_ids(7, 9);
    expect_v("m1_tag_rest", S_T1, 2);
    expect_v("m1_busy_rest", S_R1, 0);
    expect_v("m1_cnt_rest", S_CNT, 0);
    expect_v("m1_issue_ign", S_R2, 1);

    // commit of checkpointed tag scrubs the snapshot before restore
    tick(); issue(7, 2, 1);
    tick(); issue(7, 4, 0);
    tick(); commit(7, 2, 9); rd_ids(7, 0);
    expect_v("m2_nobyp", S_R1, 0);
    tick(); rd_ids(7, 0);
    expect_v("m2_still_busy", S_R1, 0);
    expect_v("m2_val_written", S_V1, 9);
    tick(); resolve(1);
    tick(); rd_ids(7, 0);
    expect_v("m2_rdy", S_R1, 1);
    expect_v("m2_val", S_V1, 9);
    expect_v("m2_tag", S_T1, 2);
    expect_v("m2_cnt", S_CNT, 0);

    // fill the FIFO, drop the extra push, pop, push+pop, wrap-around restore
    for (int i = 0; i < 4; i++) begin
      tick(); issue(5'(10 + i), RW'(1 + i), 1);
      expect_v("fill_cnt", S_CNT, 32'(i));
    end
    tick(); issue(14, 5, 1);
    expect_v("full_cnt", S_CNT, 4);
    expect_v("full_flag", S_FULL, 1);
    tick(); rd_ids(14, 0);
    expect_v("drop_cnt", S_CNT, 4);
    expect_v("drop_rename", S_T1, 5);
    expect_v("drop_busy", S_R1, 0);
    tick(); resolve(0);
    tick();
    expect_v("pop_cnt", S_CNT, 3);
    expect_v("pop_full", S_FULL, 0);
    tick(); resolve(0); issue(15, 6, 1);
    tick(); rd_ids(15, 0);
    expect_v("pushpop_cnt", S_CNT, 3);
    expect_v("pushpop_tag", S_T1, 6);
    tick(); resolve(1);
    tick(); rd_ids(12, 13);
    expect_v("wrap_r12_busy", S_R1, 0);
    expect_v("wrap_r12_tag", S_T1, 3);
    expect_v("wrap_r13_rdy", S_R2, 1);
    expect_v("wrap_r13_tag", S_T2, 0);
    expect_v("wrap_cnt", S_CNT, 0);
    tick(); rd_ids(14, 15);
    expect_v("wrap_r14_rdy", S_R1, 1);
    expect_v("wrap_r15_rdy", S_R2, 1);

    // same-cycle rename and commit of the old tag
    tick(); issue(8, 1, 0);
    tick(); issue(8, 5, 0); commit(8, 1, 32'h88); rd_ids(8, 0);
    expect_v("r8_byp_rdy", S_R1, 1);
    expect_v("r8_byp_val", S_V1, 32'h88);
    tick(); rd_ids(8, 0);
    expect_v("r8_busy", S_R1, 0);
    expect_v("r8_tag", S_T1, 5);
    expect_v("r8_val", S_V1, 32'h88);

    // mispredict with empty FIFO is ignored
    tick(); resolve(1);
    tick(); rd_ids(8, 0);
    expect_v("emp_mis_busy", S_R1, 0);
    expect_v("emp_mis_tag", S_T1, 5);

    // flush overrides issue, still takes commit value
    tick(); issue(20, 7, 1);
    tick(); bus.flush_all = 1'b1; commit(20, 7, 32'h55); issue(21, 8, 1);
    expect_v("fl_cnt_pre", S_CNT, 1);
    tick(); rd_ids(20, 21);
    expect_v("fl_r20_rdy", S_R1, 1);
    expect_v("fl_r20_val", S_V1, 32'h55);
    expect_v("fl_r20_tag", S_T1, 0);
    expect_v("fl_r21_rdy", S_R2, 1);
    expect_v("fl_cnt", S_CNT, 0);
    expect_v("fl_empty", S_EMPTY, 1);
    tick(); rd_ids(10, 8);
    expect_v("fl_r10_rdy", S_R1, 1);
    expect_v("fl_r8_rdy", S_R2, 1);

    // asynchronous reset between edges with live checkpoints
    tick(); issue(3, 1, 1);
    tick(); issue(4, 2, 1);
    tick(); rd_ids(3, 4);
    expect_v("ar_r3_busy", S_R1, 0);
    expect_v("ar_r4_busy", S_R2, 0);
    expect_v("ar_cnt_pre", S_CNT, 2);
    tick(); rst = 1'b1; rd_ids(3, 4);
    expect_v("ar_cnt", S_CNT, 0);
    expect_v("ar_empty", S_EMPTY, 1);
    expect_v("ar_r3_rdy", S_R1, 1);
    expect_v("ar_r4_rdy", S_R2, 1);
    expect_v("ar_x1", S_X1, 0);
    tick(); rst = 1'b0;
    tick(); rd_ids(3, 1);
    expect_v("post_rst_r3", S_R1, 1);
    expect_v("post_rst_v1", S_V2, 0);

    for (int k = 0; k < 5 && sb.size() > 0; k++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: actual=%0d expected=0 pending", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
